program_loader: RTL and testbench

Sequential encoder and loader for the 4-bit CPU's program memory. It accepts a stream of decoded instructions (`OPECODE` plus 4-bit immediate) over a valid/ready handshake. It encodes each instruction into the 8-bit ROM word format, `[7:4]` opcode and `[3:0]` immediate, and writes the words to consecutive ROM addresses starting at 0. Addresses after the last supplied instruction are padded with a fill word. It sits between the host/testbench program source and the program ROM write port, and holds the CPU stalled while a load is in progress.

---
 rtl/lib_cpu.sv | 21 ++
 rtl/program_loader_if.sv | 25 ++
 rtl/program_loader.sv | 167 ++++++++++++++++
 tb/tb_program_loader.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_cpu.sv
// Shared definitions for the 4-bit CPU: decoded instruction set seen by the
// program loader.
package lib_cpu;

  typedef enum logic [3:0] {
    ADD_A_IMM,
    ADD_B_IMM,
    MOV_A_IMM,
    MOV_B_IMM,
    MOV_A_B,
    MOV_B_A,
    JMP_IMM,
    JNC_IMM,
    IN_A,
    IN_B,
    OUT_B,
    OUT_IMM,
    INVALID
  } OPECODE;

endpackage

// File: rtl/program_loader_if.sv
// Instruction stream (valid/ready) and ROM write port of the program loader.
// The loader is the slave; the program source / ROM side is the master.
interface program_loader_if;
  import lib_cpu::*;

  logic        in_valid;
  logic        in_ready;
  OPECODE      in_opecode;
  logic [3:0]  in_imm;
  logic        in_last;
  logic        rom_we;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_wdata;

  modport master (
    output in_valid, in_opecode, in_imm, in_last,
    input  in_ready, rom_we, rom_addr, rom_wdata
  );

  modport slave (
    input  in_valid, in_opecode, in_imm, in_last,
    output in_ready, rom_we, rom_addr, rom_wdata
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: encodes a stream of decoded instructions into 8-bit ROM
// words, writes them from address 0 upward, pads the remainder with a fill
// word and holds the CPU while a load is in progress.
module program_loader
  import lib_cpu::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  FILL_DATA = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [4:0]       count
);

  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  ptr;
  logic [4:0]  cnt;
  logic        in_ready_c;
  logic        busy_c;
  logic        done_c;
  logic        error_c;
  logic        accept;
  logic        is_invalid;

  // ROM write stage, one cycle behind the accepting edge
  logic        we_p1;
  logic [3:0]  addr_p1;
  logic [7:0]  wdata_p1;

  // Opcode nibble plus immediate; register-only moves and I/O reads carry a
  // zero immediate field regardless of what the source supplied.
  function automatic logic [7:0] encode(input OPECODE op, input logic [3:0] imm);
    logic [3:0] opn;
    logic       zero_imm;
    opn      = 4'h0;
    zero_imm = 1'b0;
    case (op)
      ADD_A_IMM: opn = 4'b0000;
      ADD_B_IMM: opn = 4'b0101;
      MOV_A_IMM: opn = 4'b0011;
      MOV_B_IMM: opn = 4'b0111;
      MOV_A_B:   begin opn = 4'b0001; zero_imm = 1'b1; end
      MOV_B_A:   begin opn = 4'b0100; zero_imm = 1'b1; end
      JMP_IMM:   opn = 4'b1111;
      JNC_IMM:   opn = 4'b1110;
      IN_A:      begin opn = 4'b0010; zero_imm = 1'b1; end
      IN_B:      begin opn = 4'b0110; zero_imm = 1'b1; end
      OUT_B:     begin opn = 4'b1001; zero_imm = 1'b1; end
      OUT_IMM:   opn = 4'b1011;
      default:   opn = 4'b0000;
    endcase
    return {opn, (zero_imm ? 4'h0 : imm)};
  endfunction

  assign accept     = bus.in_valid && in_ready_c;
  assign is_invalid = (bus.in_opecode == INVALID);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (is_invalid)             state_nx = S_ERROR;
          else if (ptr == LAST_ADDR)  state_nx = S_DONE;
          else if (bus.in_last)       state_nx = S_PAD;
        end
      end
      S_PAD: begin
        if (ptr == LAST_ADDR) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state only
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    error_c    = 1'b0;
    case (state)
      S_LOAD:  begin in_ready_c = 1'b1; busy_c = 1'b1; end
      S_PAD:   busy_c  = 1'b1;
      S_DONE:  done_c  = 1'b1;
      S_ERROR: error_c = 1'b1;
      default: ;
    endcase
  end

  // Address pointer, word count and registered ROM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 4'd0;
      cnt      <= 5'd0;
      we_p1    <= 1'b0;
      addr_p1  <= 4'd0;
      wdata_p1 <= 8'd0;
    end else begin
      we_p1 <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            ptr <= 4'd0;
            cnt <= 5'd0;
          end
        end
        S_LOAD: begin
          if (accept && !is_invalid) begin
            we_p1    <= 1'b1;
            addr_p1  <= ptr;
            wdata_p1 <= encode(bus.in_opecode, bus.in_imm);
            ptr      <= ptr + 4'd1;
            cnt      <= cnt + 5'd1;
          end
        end
        S_PAD: begin
          we_p1    <= 1'b1;
          addr_p1  <= ptr;
          wdata_p1 <= FILL_DATA;
          ptr      <= ptr + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.rom_we    = we_p1;
  assign bus.rom_addr  = addr_p1;
  assign bus.rom_wdata = wdata_p1;
  assign busy          = busy_c;
  assign done          = done_c;
  assign error         = error_c;
  assign count         = cnt;
  assign cpu_hold      = busy_c | we_p1;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected ROM writes are queued as
// stimulus is driven and compared against the writes the ROM port produces.
module tb_program_loader;
  import lib_cpu::*;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    logic       dn;
    int         cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpu_hold, busy, done, error;
  logic [4:0] count;
  int         cyc = 0;
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  wr_t        exp_q[$];
  wr_t        obs_q[$];

  program_loader_if bus();

  program_loader #(.DEPTH(16), .FILL_DATA(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every ROM write pulse with the done flag and cycle it appeared in
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1)
      obs_q.push_back('{a: bus.rom_addr, d: bus.rom_wdata, dn: done, cyc: cyc});
  end

  function automatic logic [7:0] ref_word(input OPECODE op, input logic [3:0] imm);
    case (op)
      ADD_A_IMM: return {4'h0, imm};
      ADD_B_IMM: return {4'h5, imm};
      MOV_A_IMM: return {4'h3, imm};
      MOV_B_IMM: return {4'h7, imm};
      MOV_A_B:   return 8'h10;
      MOV_B_A:   return 8'h40;
      JMP_IMM:   return {4'hF, imm};
      JNC_IMM:   return {4'hE, imm};
      IN_A:      return 8'h20;
      IN_B:      return 8'h60;
      OUT_B:     return 8'h90;
      OUT_IMM:   return {4'hB, imm};
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic idle_bus();
    bus.in_valid   = 1'b0;
    bus.in_opecode = ADD_A_IMM;
    bus.in_imm     = 4'h0;
    bus.in_last    = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // present one beat for one cycle; the bench only calls this while in LOAD
  task automatic send(input OPECODE op, input logic [3:0] imm, input logic last);
    bus.in_valid   = 1'b1;
    bus.in_opecode = op;
    bus.in_imm     = imm;
    bus.in_last    = last;
    if (op != INVALID)
      exp_q.push_back('{a: 4'(exp_q.size()), d: ref_word(op, imm), dn: 1'b0, cyc: 0});
    @(posedge clk); #1;
  endtask

  task automatic push_pads();
    for (int a = exp_q.size(); a < 16; a++)
      exp_q.push_back('{a: 4'(a), d: 8'h00, dn: 1'b0, cyc: 0});
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < n && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({bus.in_ready, bus.rom_we, cpu_hold, busy, done, error} !== 6'b0)
      $display("FAIL reset_ctrl got %b required 000000",
               {bus.in_ready, bus.rom_we, cpu_hold, busy, done, error});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.rom_addr, bus.rom_wdata, count} !== 17'd0)
      $display("FAIL reset_data addr=%0d wdata=%02h count=%0d required all 0",
               bus.rom_addr, bus.rom_wdata, count);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_basic();
    wr_t e, o;
    int  prev_cyc, gaps, dn_bad;
    do_start();
    send(MOV_A_IMM, 4'd3, 1'b0);
    send(ADD_A_IMM, 4'd1, 1'b0);
    send(OUT_B,     4'd7, 1'b0);
    send(JMP_IMM,   4'd0, 1'b1);
    idle_bus();
    push_pads();
    wait_done(40);
    chk_cnt++;
    if (done !== 1'b1 || bus.rom_we !== 1'b1 || bus.rom_addr !== 4'd15 || cpu_hold !== 1'b1)
      $display("FAIL basic_done_edge done=%b we=%b addr=%0d hold=%b required 1 1 15 1",
               done, bus.rom_we, bus.rom_addr, cpu_hold);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (cpu_hold !== 1'b0 || done !== 1'b1 || count !== 5'd4)
      $display("FAIL basic_after hold=%b done=%b count=%0d required 0 1 4", cpu_hold, done, count);
    else pass_cnt++;
    prev_cyc = -1; gaps = 0; dn_bad = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL basic_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (prev_cyc >= 0 && o.cyc != prev_cyc + 1) gaps++;
        if (o.dn !== (e.a == 4'd15)) dn_bad++;
        prev_cyc = o.cyc;
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL basic_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (gaps !== 0) $display("FAIL basic_consecutive gaps=%0d required 0", gaps);
    else pass_cnt++;
    chk_cnt++;
    if (dn_bad !== 0) $display("FAIL basic_done_timing bad=%0d required 0", dn_bad);
    else pass_cnt++;
  endtask

  task automatic test_zero_nibble();
    wr_t e, o;
    obs_q.delete();
    do_start();
    send(MOV_A_B, 4'd5, 1'b0);
    send(IN_B,    4'd9, 1'b0);
    send(OUT_IMM, 4'hA, 1'b1);
    idle_bus();
    push_pads();
    wait_done(40);
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b1 || count !== 5'd3)
      $display("FAIL zero_done done=%b count=%0d required 1 3", done, count);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL zero_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL zero_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_full_gaps();
    wr_t e, o;
    obs_q.delete();
    do_start();
    for (int k = 0; k < 16; k++) begin
      if (k % 3 == 2) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(ADD_B_IMM, 4'(k), 1'b0);
    end
    idle_bus();
    wait_done(10);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (done !== 1'b1 || count !== 5'd16 || bus.in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL full_status done=%b count=%0d ready=%b busy=%b required 1 16 0 0",
               done, count, bus.in_ready, busy);
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() != 16) $display("FAIL full_nwrites got %0d required 16", obs_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (obs_q.size() > 0 && obs_q[obs_q.size()-1].dn !== 1'b1)
      $display("FAIL full_done_with_last got %b required 1", obs_q[obs_q.size()-1].dn);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL full_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL full_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_invalid();
    wr_t e, o;
    obs_q.delete();
    do_start();
    send(ADD_A_IMM, 4'd1, 1'b0);
    send(MOV_B_IMM, 4'd2, 1'b0);
    send(INVALID,   4'd3, 1'b0);
    idle_bus();
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (error !== 1'b1 || done !== 1'b0 || count !== 5'd2 || cpu_hold !== 1'b0 || bus.rom_we !== 1'b0)
      $display("FAIL inv_status err=%b done=%b count=%0d hold=%b we=%b required 1 0 2 0 0",
               error, done, count, cpu_hold, bus.rom_we);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL inv_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL inv_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL inv_extra_writes got %0d required 0", obs_q.size());
    else pass_cnt++;
    obs_q.delete();
    do_start();
    @(negedge clk);
    chk_cnt++;
    if (error !== 1'b0 || busy !== 1'b1 || count !== 5'd0)
      $display("FAIL inv_restart err=%b busy=%b count=%0d required 0 1 0", error, busy, count);
    else pass_cnt++;
    @(posedge clk); #1;
    send(JNC_IMM, 4'd4, 1'b1);
    idle_bus();
    push_pads();
    wait_done(40);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL inv_rewrite missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL inv_rewrite got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_in_pad();
    wr_t e, o;
    int  n;
    obs_q.delete();
    do_start();
    send(MOV_A_IMM, 4'd3, 1'b1);
    idle_bus();
    for (int a = 1; a <= 8; a++)
      exp_q.push_back('{a: 4'(a), d: 8'h00, dn: 1'b0, cyc: 0});
    n = 0;
    while (n < 20 && !(bus.rom_we === 1'b1 && bus.rom_addr == 4'd4)) begin
      @(negedge clk); n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20 && !(bus.rom_we === 1'b1 && bus.rom_addr == 4'd8)) begin
      @(negedge clk); n++;
    end
    chk_cnt++;
    if (n >= 20) $display("FAIL pad_reach_addr8 timeout after %0d cycles, required addr 8 write", n);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({bus.in_ready, bus.rom_we, cpu_hold, busy, done, error} !== 6'b0 ||
        {bus.rom_addr, bus.rom_wdata, count} !== 17'd0)
      $display("FAIL pad_rst_outputs ctrl=%b addr=%0d wdata=%02h count=%0d required all 0",
               {bus.in_ready, bus.rom_we, cpu_hold, busy, done, error},
               bus.rom_addr, bus.rom_wdata, count);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL pad_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL pad_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL pad_after_rst writes=%0d required 0", obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_start_with_valid();
    wr_t e, o;
    int  p;
    obs_q.delete();
    @(posedge clk); #1;
    p = cyc;
    start          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_opecode = OUT_IMM;
    bus.in_imm     = 4'd5;
    bus.in_last    = 1'b1;
    exp_q.push_back('{a: 4'd0, d: ref_word(OUT_IMM, 4'd5), dn: 1'b0, cyc: 0});
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b0) $display("FAIL sv_ready_idle got %b required 0", bus.in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL sv_ready_load ready=%b busy=%b required 1 1", bus.in_ready, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    idle_bus();
    push_pads();
    wait_done(40);
    @(negedge clk);
    chk_cnt++;
    if (obs_q.size() == 0 || obs_q[0].cyc != p + 2)
      $display("FAIL sv_first_write_cycle got %0d required %0d",
               (obs_q.size() == 0) ? -1 : obs_q[0].cyc - p, 2);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_cnt++;
      if (obs_q.size() == 0) begin
        $display("FAIL sv_write missing, required %02h@%0d", e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.a !== e.a || o.d !== e.d)
          $display("FAIL sv_write got %02h@%0d required %02h@%0d", o.d, o.a, e.d, e.a);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_nibble();
    test_full_gaps();
    test_invalid();
    test_reset_in_pad();
    test_start_with_valid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
